// File: rtl/sargantana_icache_ifill_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sargantana_icache_pkg
// Shared types for the icache iFill arbiter: arbiter state, refill owner and
// a helper that qualifies a real refill response from an upper-level message.
// ----------------------------------------------------------------------------
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_PADDR_W = 40;
  localparam int unsigned ICACHE_N_WAY   = 4;
  localparam int unsigned IFILL_TIMEOUT  = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no refill outstanding
    WAIT  = 2'd1,  // refill outstanding, owner known
    DRAIN = 2'd2   // refill outstanding, owner cancelled; response is discarded
  } ifill_arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DEM  = 2'd1,
    OWN_PF   = 2'd2
  } ifill_owner_t;

  // Invalidations share the response valid but never carry refill data.
  function automatic logic is_refill(input logic resp_valid, input logic resp_inv);
    return resp_valid & ~resp_inv;
  endfunction

endpackage

// File: rtl/sargantana_icache_ifill_arbiter_if.sv
// ----------------------------------------------------------------------------
// sargantana_icache_ifill_arbiter_if
// Bundles the handshake signals around the iFill arbiter:
//   - demand miss request (valid/ready/paddr/way) plus core kill
//   - prefetch request (valid/ready/paddr/way)
//   - iFill request to upper levels (valid pulse/paddr/way)
//   - iFill response from upper levels (valid/inv)
//   - per-owner response valids back to the icache
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding icache / upper-level environment
// ----------------------------------------------------------------------------
interface sargantana_icache_ifill_arbiter_if #(
  parameter int unsigned PADDR_W = 40,
  parameter int unsigned WAY_W   = 2
);

  logic               dem_req_valid_i;
  logic               dem_req_ready_o;
  logic [PADDR_W-1:0] dem_req_paddr_i;
  logic [WAY_W-1:0]   dem_req_way_i;
  logic               dem_kill_i;

  logic               pf_req_valid_i;
  logic               pf_req_ready_o;
  logic [PADDR_W-1:0] pf_req_paddr_i;
  logic [WAY_W-1:0]   pf_req_way_i;

  logic               ifill_req_valid_o;
  logic [PADDR_W-1:0] ifill_req_paddr_o;
  logic [WAY_W-1:0]   ifill_req_way_o;

  logic               ifill_resp_valid_i;
  logic               ifill_resp_inv_i;

  logic               dem_resp_valid_o;
  logic               pf_resp_valid_o;

  modport slave (
    input  dem_req_valid_i, dem_req_paddr_i, dem_req_way_i, dem_kill_i,
    input  pf_req_valid_i, pf_req_paddr_i, pf_req_way_i,
    input  ifill_resp_valid_i, ifill_resp_inv_i,
    output dem_req_ready_o, pf_req_ready_o,
    output ifill_req_valid_o, ifill_req_paddr_o, ifill_req_way_o,
    output dem_resp_valid_o, pf_resp_valid_o
  );

  modport master (
    output dem_req_valid_i, dem_req_paddr_i, dem_req_way_i, dem_kill_i,
    output pf_req_valid_i, pf_req_paddr_i, pf_req_way_i,
    output ifill_resp_valid_i, ifill_resp_inv_i,
    input  dem_req_ready_o, pf_req_ready_o,
    input  ifill_req_valid_o, ifill_req_paddr_o, ifill_req_way_o,
    input  dem_resp_valid_o, pf_resp_valid_o
  );

endinterface

// File: rtl/sargantana_icache_ifill_arbiter.sv
// ----------------------------------------------------------------------------
// sargantana_icache_ifill_arbiter
// Shares the single iFill request/response channel between the icache
// demand-miss path and the next-line prefetcher. At most one refill is
// outstanding; its owner is tracked so the response is routed back to the
// right requester, or silently dropped after a kill/flush.
//
// Ports:
//   clk_i         clock, all state on rising edge
//   rstn_i        asynchronous active-low reset
//   flush_i       icache flush; cancels ownership of an outstanding refill
//   bus           arbiter handshakes (slave modport): demand/prefetch requests,
//                 iFill request/response, per-owner response valids
//   busy_o        a refill is outstanding
//   err_timeout_o one-cycle pulse when an outstanding refill reaches TIMEOUT
// ----------------------------------------------------------------------------
module sargantana_icache_ifill_arbiter
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned PADDR_W = ICACHE_PADDR_W,
  parameter int unsigned N_WAY   = ICACHE_N_WAY,
  parameter int unsigned TIMEOUT = IFILL_TIMEOUT
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic flush_i,
  sargantana_icache_ifill_arbiter_if.slave bus,
  output logic busy_o,
  output logic err_timeout_o
);

  localparam int unsigned WAY_W   = (N_WAY > 1) ? $clog2(N_WAY) : 1;
  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  ifill_arb_state_t   state_q, state_d;
  ifill_owner_t       owner_q, owner_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [TIMER_W-1:0] timer_q;
  logic               err_q;

  logic               refill_ok;
  logic               cancel;
  logic               promote;
  logic               dem_ready;
  logic               pf_ready;
  logic               req_valid;
  logic [PADDR_W-1:0] req_paddr;
  logic [WAY_W-1:0]   req_way;
  logic               dem_resp;
  logic               pf_resp;

  assign refill_ok = is_refill(bus.ifill_resp_valid_i, bus.ifill_resp_inv_i);

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    paddr_d   = paddr_q;
    way_d     = way_q;
    cancel    = 1'b0;
    promote   = 1'b0;
    dem_ready = 1'b0;
    pf_ready  = 1'b0;
    req_valid = 1'b0;
    req_paddr = '0;
    req_way   = '0;
    dem_resp  = 1'b0;
    pf_resp   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Demand has fixed priority: a pending demand masks prefetch ready.
        dem_ready = ~flush_i;
        pf_ready  = ~flush_i & ~bus.dem_req_valid_i;
        if (bus.dem_req_valid_i && dem_ready) begin
          // A demand killed in the same cycle is consumed without a request.
          if (!bus.dem_kill_i) begin
            req_valid = 1'b1;
            req_paddr = bus.dem_req_paddr_i;
            req_way   = bus.dem_req_way_i;
            paddr_d   = bus.dem_req_paddr_i;
            way_d     = bus.dem_req_way_i;
            owner_d   = OWN_DEM;
            state_d   = WAIT;
          end
        end else if (bus.pf_req_valid_i && pf_ready) begin
          req_valid = 1'b1;
          req_paddr = bus.pf_req_paddr_i;
          req_way   = bus.pf_req_way_i;
          paddr_d   = bus.pf_req_paddr_i;
          way_d     = bus.pf_req_way_i;
          owner_d   = OWN_PF;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        cancel = flush_i | ((owner_q == OWN_DEM) & bus.dem_kill_i);
        // A demand for the line already being prefetched rides on that refill;
        // the prefetch way is kept since the request is already in flight.
        dem_ready = (owner_q == OWN_PF) & bus.dem_req_valid_i & ~flush_i &
                    (bus.dem_req_paddr_i == paddr_q);
        promote   = dem_ready & ~bus.dem_kill_i;
        if (refill_ok) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
          if (!cancel) begin
            if ((owner_q == OWN_DEM) || promote) dem_resp = 1'b1;
            else                                  pf_resp  = 1'b1;
          end
        end else if (cancel) begin
          state_d = DRAIN;
          owner_d = OWN_NONE;
        end else if (promote) begin
          owner_d = OWN_DEM;
        end
      end

      DRAIN: begin
        if (refill_ok) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, latched request and refill timer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      paddr_q <= '0;
      way_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      owner_q <= owner_d;
      paddr_q <= paddr_d;
      way_q   <= way_d;
      // Timer runs only while a refill is outstanding and saturates at
      // TIMEOUT, so the error fires exactly once per stuck refill.
      if (state_d == IDLE) begin
        timer_q <= '0;
      end else if ((state_q != IDLE) && (timer_q != TIMER_MAX)) begin
        timer_q <= timer_q + TIMER_W'(1);
      end
      err_q <= (state_q != IDLE) && (state_d != IDLE) && (timer_q == TIMER_LAST);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // NOTE: the IDLE readies and the zero-latency request are combinational from
  // the inputs, so they are qualified with rstn_i to hold every output at 0
  // for as long as reset is asserted, not just from the next clock edge.
  assign bus.dem_req_ready_o   = rstn_i & dem_ready;
  assign bus.pf_req_ready_o    = rstn_i & pf_ready;
  assign bus.ifill_req_valid_o = rstn_i & req_valid;
  assign bus.ifill_req_paddr_o = rstn_i ? req_paddr : '0;
  assign bus.ifill_req_way_o   = rstn_i ? req_way : '0;
  assign bus.dem_resp_valid_o  = rstn_i & dem_resp;
  assign bus.pf_resp_valid_o   = rstn_i & pf_resp;

  assign busy_o        = (state_q != IDLE);
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_sargantana_icache_ifill_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sargantana_icache_ifill_arbiter
// Scoreboard bench: stimulus pushes expected output events (iFill request,
// demand/prefetch response, timeout pulse) tagged with the cycle they must
// appear in, plus level probes for ready/busy. A single negedge monitor pops
// and compares; any output event with nothing expected is reported.
// ----------------------------------------------------------------------------
module tb_sargantana_icache_ifill_arbiter;
  import sargantana_icache_pkg::*;

  localparam int unsigned PADDR_W = 40;
  localparam int unsigned N_WAY   = 4;
  localparam int unsigned WAY_W   = 2;
  localparam int unsigned TIMEOUT = 1023;

  logic clk_i   = 1'b0;
  logic rstn_i  = 1'b0;
  logic flush_i = 1'b0;
  logic busy_o;
  logic err_timeout_o;

  sargantana_icache_ifill_arbiter_if #(.PADDR_W(PADDR_W), .WAY_W(WAY_W)) bus ();

  sargantana_icache_ifill_arbiter #(
    .PADDR_W(PADDR_W),
    .N_WAY  (N_WAY),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (flush_i),
    .bus          (bus.slave),
    .busy_o       (busy_o),
    .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef enum int {EV_REQ, EV_DEM_RESP, EV_PF_RESP, EV_TIMEOUT} ev_kind_t;
  typedef enum int {SIG_DEM_READY, SIG_PF_READY, SIG_BUSY, SIG_ERR,
                    SIG_REQ, SIG_DEM_RESP, SIG_PF_RESP} sig_t;

  typedef struct {
    ev_kind_t           kind;
    logic [PADDR_W-1:0] paddr;
    logic [WAY_W-1:0]   way;
    int                 at_cyc;
  } ev_t;

  typedef struct {
    string name;
    sig_t  sig;
    logic  value;
  } probe_t;

  ev_t    sb_q[$];
  probe_t probe_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     done   = 1'b0;

  // ---------------- scoreboard side (monitor process only) ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic observe(input ev_kind_t k, input logic [PADDR_W-1:0] p, input logic [WAY_W-1:0] w);
    ev_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s cyc=%0d actual=1 required=0", k.name(), cyc);
    end else begin
      e = sb_q.pop_front();
      check({"ev_kind_", e.kind.name()}, k, e.kind);
      check({"ev_cycle_", e.kind.name()}, cyc, e.at_cyc);
      if (e.kind == EV_REQ) begin
        check("req_paddr", p, e.paddr);
        check("req_way", w, e.way);
      end
    end
  endtask

  function automatic logic sample(input sig_t s);
    case (s)
      SIG_DEM_READY: return bus.dem_req_ready_o;
      SIG_PF_READY:  return bus.pf_req_ready_o;
      SIG_BUSY:      return busy_o;
      SIG_ERR:       return err_timeout_o;
      SIG_REQ:       return bus.ifill_req_valid_o;
      SIG_DEM_RESP:  return bus.dem_resp_valid_o;
      default:       return bus.pf_resp_valid_o;
    endcase
  endfunction

  always @(negedge clk_i) begin
    probe_t pr;
    if (bus.ifill_req_valid_o) observe(EV_REQ, bus.ifill_req_paddr_o, bus.ifill_req_way_o);
    if (bus.dem_resp_valid_o)  observe(EV_DEM_RESP, '0, '0);
    if (bus.pf_resp_valid_o)   observe(EV_PF_RESP, '0, '0);
    if (err_timeout_o)         observe(EV_TIMEOUT, '0, '0);
    while (probe_q.size() > 0) begin
      pr = probe_q.pop_front();
      check(pr.name, sample(pr.sig), pr.value);
    end
    if (done) begin
      check("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus side ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [PADDR_W-1:0] p,
                           input logic [WAY_W-1:0] w, input int delay);
    ev_t e;
    e.kind   = k;
    e.paddr  = p;
    e.way    = w;
    e.at_cyc = cyc + delay;
    sb_q.push_back(e);
  endtask

  task automatic probe(input string name, input sig_t s, input logic v);
    probe_t p;
    p.name  = name;
    p.sig   = s;
    p.value = v;
    probe_q.push_back(p);
  endtask

  task automatic dem(input logic v, input logic [PADDR_W-1:0] p, input logic [WAY_W-1:0] w);
    bus.dem_req_valid_i = v;
    bus.dem_req_paddr_i = p;
    bus.dem_req_way_i   = w;
  endtask

  task automatic pf(input logic v, input logic [PADDR_W-1:0] p, input logic [WAY_W-1:0] w);
    bus.pf_req_valid_i = v;
    bus.pf_req_paddr_i = p;
    bus.pf_req_way_i   = w;
  endtask

  task automatic resp(input logic v, input logic inv);
    bus.ifill_resp_valid_i = v;
    bus.ifill_resp_inv_i   = inv;
  endtask

  initial begin
    bus.dem_kill_i = 1'b0;
    resp(1'b0, 1'b0);
    pf(1'b0, '0, '0);
    // Reset with a demand pending: everything must still read 0.
    dem(1'b1, 40'h1000, 2'd2);
    probe("rst_dem_ready", SIG_DEM_READY, 1'b0);
    probe("rst_pf_ready", SIG_PF_READY, 1'b0);
    probe("rst_req", SIG_REQ, 1'b0);
    probe("rst_busy", SIG_BUSY, 1'b0);
    probe("rst_err", SIG_ERR, 1'b0);
    repeat (2) tick();
    dem(1'b0, '0, '0);
    rstn_i = 1'b1;
    tick();

    // 1: demand only, zero-latency request, response 5 cycles later.
    dem(1'b1, 40'h1000, 2'd2);
    expect_ev(EV_REQ, 40'h1000, 2'd2, 0);
    probe("t1_dem_ready", SIG_DEM_READY, 1'b1);
    probe("t1_busy_idle", SIG_BUSY, 1'b0);
    tick();
    dem(1'b0, '0, '0);
    probe("t1_busy_wait", SIG_BUSY, 1'b1);
    repeat (4) tick();
    resp(1'b1, 1'b0);
    expect_ev(EV_DEM_RESP, '0, '0, 0);
    probe("t1_busy_resp", SIG_BUSY, 1'b1);
    tick();
    resp(1'b0, 1'b0);
    probe("t1_busy_done", SIG_BUSY, 1'b0);

    // 2: simultaneous demand + prefetch, demand wins, prefetch follows.
    tick();
    dem(1'b1, 40'h2000, 2'd1);
    pf(1'b1, 40'h2020, 2'd3);
    expect_ev(EV_REQ, 40'h2000, 2'd1, 0);
    probe("t2_pf_ready_blocked", SIG_PF_READY, 1'b0);
    probe("t2_dem_ready", SIG_DEM_READY, 1'b1);
    tick();
    dem(1'b0, '0, '0);
    probe("t2_pf_ready_wait", SIG_PF_READY, 1'b0);
    tick();
    resp(1'b1, 1'b0);
    expect_ev(EV_DEM_RESP, '0, '0, 0);
    tick();
    resp(1'b0, 1'b0);
    expect_ev(EV_REQ, 40'h2020, 2'd3, 0);
    probe("t2_pf_ready_idle", SIG_PF_READY, 1'b1);
    tick();
    pf(1'b0, '0, '0);
    tick();
    resp(1'b1, 1'b0);
    expect_ev(EV_PF_RESP, '0, '0, 0);
    tick();
    resp(1'b0, 1'b0);

    // 3: promotion of an outstanding prefetch by a matching demand.
    pf(1'b1, 40'h3020, 2'd0);
    expect_ev(EV_REQ, 40'h3020, 2'd0, 0);
    tick();
    pf(1'b0, '0, '0);
    dem(1'b1, 40'h3040, 2'd1);
    probe("t3_dem_ready_nomatch", SIG_DEM_READY, 1'b0);
    tick();
    dem(1'b1, 40'h3020, 2'd2);
    probe("t3_dem_ready_match", SIG_DEM_READY, 1'b1);
    tick();
    dem(1'b0, '0, '0);
    resp(1'b1, 1'b0);
    expect_ev(EV_DEM_RESP, '0, '0, 0);
    tick();
    resp(1'b0, 1'b0);

    // Demand accepted and killed in the same IDLE cycle: no request.
    bus.dem_kill_i = 1'b1;
    dem(1'b1, 40'h3800, 2'd1);
    probe("kidle_dem_ready", SIG_DEM_READY, 1'b1);
    tick();
    bus.dem_kill_i = 1'b0;
    dem(1'b0, '0, '0);
    probe("kidle_busy", SIG_BUSY, 1'b0);

    // 4: kill at cycle 2, response at cycle 6 dropped, new demand at cycle 7.
    tick();
    dem(1'b1, 40'h4000, 2'd1);
    expect_ev(EV_REQ, 40'h4000, 2'd1, 0);
    tick();
    dem(1'b0, '0, '0);
    tick();
    bus.dem_kill_i = 1'b1;
    probe("t4_busy_kill", SIG_BUSY, 1'b1);
    tick();
    bus.dem_kill_i = 1'b0;
    dem(1'b1, 40'h4000, 2'd1);
    probe("t4_busy_drain", SIG_BUSY, 1'b1);
    probe("t4_dem_ready_drain", SIG_DEM_READY, 1'b0);
    tick();
    dem(1'b0, '0, '0);
    tick();
    tick();
    resp(1'b1, 1'b0);
    probe("t4_dem_resp_dropped", SIG_DEM_RESP, 1'b0);
    probe("t4_pf_resp_dropped", SIG_PF_RESP, 1'b0);
    tick();
    resp(1'b0, 1'b0);
    dem(1'b1, 40'h5000, 2'd0);
    expect_ev(EV_REQ, 40'h5000, 2'd0, 0);
    probe("t4_dem_ready_after", SIG_DEM_READY, 1'b1);
    tick();
    dem(1'b0, '0, '0);
    tick();
    resp(1'b1, 1'b0);
    expect_ev(EV_DEM_RESP, '0, '0, 0);
    tick();
    resp(1'b0, 1'b0);

    // Flush cancels an outstanding prefetch; flush in IDLE blocks readies.
    pf(1'b1, 40'h5800, 2'd1);
    expect_ev(EV_REQ, 40'h5800, 2'd1, 0);
    tick();
    pf(1'b0, '0, '0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    probe("fl_busy_drain", SIG_BUSY, 1'b1);
    tick();
    resp(1'b1, 1'b0);
    probe("fl_pf_resp_dropped", SIG_PF_RESP, 1'b0);
    tick();
    resp(1'b0, 1'b0);
    probe("fl_busy_idle", SIG_BUSY, 1'b0);
    flush_i = 1'b1;
    dem(1'b1, 40'h5900, 2'd3);
    probe("fl_dem_ready_idle", SIG_DEM_READY, 1'b0);
    tick();
    flush_i = 1'b0;
    dem(1'b0, '0, '0);

    // 5: invalidation during WAIT changes nothing; real refill completes.
    tick();
    dem(1'b1, 40'h6000, 2'd3);
    expect_ev(EV_REQ, 40'h6000, 2'd3, 0);
    tick();
    dem(1'b0, '0, '0);
    tick();
    resp(1'b1, 1'b1);
    probe("t5_inv_no_dem_resp", SIG_DEM_RESP, 1'b0);
    tick();
    resp(1'b0, 1'b0);
    probe("t5_busy_after_inv", SIG_BUSY, 1'b1);
    tick();
    resp(1'b1, 1'b0);
    expect_ev(EV_DEM_RESP, '0, '0, 0);
    tick();
    resp(1'b0, 1'b0);
    probe("t5_busy_done", SIG_BUSY, 1'b0);

    // 6: no response: WAIT starts the cycle after the request, the timer hits
    // TIMEOUT after 1023 WAIT cycles and the pulse is visible one cycle later.
    tick();
    dem(1'b1, 40'h7000, 2'd2);
    expect_ev(EV_REQ, 40'h7000, 2'd2, 0);
    expect_ev(EV_TIMEOUT, '0, '0, TIMEOUT + 1);
    tick();
    dem(1'b0, '0, '0);
    repeat (1030) tick();
    probe("t6_busy_stuck", SIG_BUSY, 1'b1);
    probe("t6_err_single", SIG_ERR, 1'b0);
    tick();
    #1;
    rstn_i = 1'b0;
    dem(1'b1, 40'h7100, 2'd1);
    probe("t6_rst_busy", SIG_BUSY, 1'b0);
    probe("t6_rst_dem_ready", SIG_DEM_READY, 1'b0);
    probe("t6_rst_req", SIG_REQ, 1'b0);
    probe("t6_rst_err", SIG_ERR, 1'b0);
    tick();
    dem(1'b0, '0, '0);
    rstn_i = 1'b1;
    tick();
    resp(1'b1, 1'b0);
    probe("t6_stray_busy", SIG_BUSY, 1'b0);
    probe("t6_stray_dem_resp", SIG_DEM_RESP, 1'b0);
    tick();
    resp(1'b0, 1'b0);
    probe("t6_stray_busy_after", SIG_BUSY, 1'b0);
    repeat (3) tick();
    done = 1'b1;
  end

endmodule
